// File: rtl/zp_loader_pkg.sv
// zp_loader_pkg: shared types and helpers for the zero-padded ifmap loader
package zp_loader_pkg;
  typedef logic [15:0] bf16_t;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} zp_state_t;
  function automatic int padded_dim(input int ih, input int p);
    return ih + 2 * p;
  endfunction
endpackage

// File: rtl/zp_coord_counter.sv
// zp_coord_counter: nested ch/row/col walker, col fastest, with last-coordinate flag
module zp_coord_counter #(
  parameter int C = 3,
  parameter int IH = 4,
  localparam int CW = C > 1 ? $clog2(C) : 1,
  localparam int HW = IH > 1 ? $clog2(IH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] ch,
  output logic [HW-1:0] row,
  output logic [HW-1:0] col,
  output logic          last
);
  logic col_end, row_end;
  assign col_end = col == HW'(IH - 1);
  assign row_end = row == HW'(IH - 1);
  assign last = col_end && row_end && ch == CW'(C - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ch <= '0;
      row <= '0;
      col <= '0;
    end else if (clear) begin
      ch <= '0;
      row <= '0;
      col <= '0;
    end else if (advance) begin
      col <= col_end ? '0 : col + 1'b1;
      if (col_end) row <= row_end ? '0 : row + 1'b1;
      if (col_end && row_end) ch <= last ? '0 : ch + 1'b1;
    end
endmodule

// File: rtl/ifmap_zeropad_loader.sv
// ifmap_zeropad_loader: streams one ifmap into a zero-bordered register buffer.
// Optional abort input enabled by ZP_LOADER_ABORT_EN.
module ifmap_zeropad_loader
  import zp_loader_pkg::*;
#(
  parameter int C = 3,
  parameter int iH = 4,
  parameter int P = 1,
  parameter int BW = 16,
  localparam int D = padded_dim(iH, P),
  localparam int CW = C > 1 ? $clog2(C) : 1,
  localparam int HW = iH > 1 ? $clog2(iH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef ZP_LOADER_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  output logic          done,
  output logic          buf_valid,
  output logic          busy,
  output logic [BW-1:0] ifmap_zeropad [0:C-1][0:D-1][0:D-1]
);
  zp_state_t state;
  logic [CW-1:0] ch;
  logic [HW-1:0] row, col;
  logic last, accept, abort_hit;
  logic [BW-1:0] core [C][iH][iH];
`ifdef ZP_LOADER_ABORT_EN
  assign abort_hit = abort && state == LOAD;
`else
  assign abort_hit = 1'b0;
`endif
  assign in_ready = state == LOAD;
  assign busy = state == LOAD;
  assign accept = in_ready && in_valid && !abort_hit;
  zp_coord_counter #(.C(C), .IH(iH)) u_cnt (
    .clk(clk), .rst_n(rst_n),
    .clear((state == IDLE && start) || abort_hit),
    .advance(accept),
    .ch(ch), .row(row), .col(col), .last(last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          buf_valid <= 1'b0;
        end
        LOAD: if (abort_hit) state <= IDLE;
        else if (accept && last) begin
          state <= DONE;
          done <= 1'b1;
          buf_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < C; i++)
        for (int j = 0; j < iH; j++)
          for (int k = 0; k < iH; k++) core[i][j][k] <= '0;
    end else if (accept) core[ch][row][col] <= in_data;
  // Only interior cells have storage; the border is tied to zero.
  for (genvar c = 0; c < C; c++) begin : g_ch
    for (genvar r = 0; r < D; r++) begin : g_row
      for (genvar k = 0; k < D; k++) begin : g_col
        if (r >= P && r < iH + P && k >= P && k < iH + P) begin : g_in
          assign ifmap_zeropad[c][r][k] = core[c][r-P][k-P];
        end else begin : g_bd
          assign ifmap_zeropad[c][r][k] = '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ifmap_zeropad_loader.sv
// tb_ifmap_zeropad_loader: scoreboard + table-driven bench for the zero-pad loader
module tb_ifmap_zeropad_loader;
  localparam int C = 3, IH = 4, P = 1, D = 6, N = C * IH * IH;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, abort = 0;
  logic [15:0] in_data = '0;
  logic in_ready, done, buf_valid, busy;
  logic [15:0] zp [0:C-1][0:D-1][0:D-1];
  typedef struct {int ch; int r; int c; logic [15:0] d;} wr_t;
  typedef struct {string name; int ch; int r; int c; logic [15:0] exp;} vec_t;
  wr_t sb[$];
  vec_t tbl[9];
  logic [15:0] m [C][IH][IH];
  int n_acc, errors = 0, checks = 0;

  ifmap_zeropad_loader #(.C(C), .iH(IH), .P(P), .BW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ZP_LOADER_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .done(done), .buf_valid(buf_valid), .busy(busy), .ifmap_zeropad(zp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    wr_t w;
    while (sb.size() > 0) begin
      w = sb.pop_front();
      m[w.ch][w.r][w.c] = w.d;
    end
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < C; i++)
      for (int j = 0; j < IH; j++)
        for (int k = 0; k < IH; k++) m[i][j][k] = '0;
  endtask

  function automatic logic [15:0] data_of(input int mode, input int n);
    case (mode)
      0: return 16'(n + 1);
      1: return 16'(32'h1000 + n);
      2: return 16'hFFFF;
      default: return 16'(n * 7 + 3);
    endcase
  endfunction

  task automatic cmp_buf(input string name);
    int bad = 0;
    logic [15:0] e, fa, fe;
    int fc, fr, fk;
    for (int c = 0; c < C; c++)
      for (int r = 0; r < D; r++)
        for (int k = 0; k < D; k++) begin
          e = (r >= P && r < IH + P && k >= P && k < IH + P) ? m[c][r-P][k-P] : 16'h0;
          if (zp[c][r][k] !== e) begin
            if (bad == 0) begin fa = zp[c][r][k]; fe = e; fc = c; fr = r; fk = k; end
            bad++;
          end
        end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d cells wrong, first [%0d][%0d][%0d] got %h expected %h",
               name, bad, fc, fr, fk, fa, fe);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic ab);
    in_valid = v;
    in_data = d;
    abort = ab;
    if (v && in_ready && !ab) begin
      sb.push_back('{n_acc / (IH * IH), (n_acc / IH) % IH, n_acc % IH, d});
      n_acc++;
    end
    step();
  endtask

  task automatic load(input int mode, input bit gaps, input int stop_at, input int abort_at);
    int cyc = 0;
    logic v, ab;
    n_acc = 0;
    start = 1;
    step();
    start = 0;
    chk("start_ready", {31'b0, in_ready}, 1);
    chk("start_bufv_clear", {31'b0, buf_valid}, 0);
    while (n_acc < stop_at && cyc < 400) begin
      v = !gaps || (cyc % 3 == 0);
      start = mode == 3 && n_acc == 3 && v;
      ab = abort_at == n_acc;
      drive(v, data_of(mode, n_acc), ab);
      start = 0;
      if (ab) break;
      cyc++;
    end
    in_valid = 0;
    abort = 0;
    if (abort_at < 0 && n_acc < stop_at) chk("load_timeout", n_acc, stop_at);
  endtask

  task automatic finish_load(input string name);
    chk({name, "_done"}, {31'b0, done}, 1);
    chk({name, "_bufv"}, {31'b0, buf_valid}, 1);
    drain();
    cmp_buf(name);
    step();
    chk({name, "_done_once"}, {31'b0, done}, 0);
  endtask

  initial begin
    tbl[0] = '{"b011", 0, 1, 1, 16'h0001};
    tbl[1] = '{"b044", 0, 4, 4, 16'h0010};
    tbl[2] = '{"b111", 1, 1, 1, 16'h0011};
    tbl[3] = '{"b123", 1, 2, 3, 16'h0017};
    tbl[4] = '{"b244", 2, 4, 4, 16'h0030};
    tbl[5] = '{"b214", 2, 1, 4, 16'h0024};
    tbl[6] = '{"b000", 0, 0, 0, 16'h0000};
    tbl[7] = '{"b255", 2, 5, 5, 16'h0000};
    tbl[8] = '{"b130", 1, 3, 0, 16'h0000};
    clear_model();
    repeat (3) step();
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_bufv", {31'b0, buf_valid}, 0);
    cmp_buf("rst_buffer");
    rst_n = 1;
    step();
    // basic back-to-back load
    load(0, 0, N, -1);
    chk("basic_busy_off", {31'b0, busy}, 0);
    finish_load("basic");
    for (int i = 0; i < 9; i++) chk(tbl[i].name, zp[tbl[i].ch][tbl[i].r][tbl[i].c], tbl[i].exp);
    chk("idle_bufv_hold", {31'b0, buf_valid}, 1);
    in_valid = 1;
    in_data = 16'hDEAD;
    step();
    chk("idle_not_ready", {31'b0, in_ready}, 0);
    step();
    in_valid = 0;
    cmp_buf("idle_ignore");
    // gapped in_valid
    load(1, 1, N, -1);
    finish_load("gaps");
    // all-ones data, border must stay zero
    load(2, 0, N, -1);
    finish_load("border");
    begin
      logic [15:0] acc = '0;
      for (int c = 0; c < C; c++)
        for (int i = 0; i < D; i++) acc |= zp[c][0][i] | zp[c][D-1][i] | zp[c][i][0] | zp[c][i][D-1];
      chk("border_zero", acc, 0);
      chk("interior_ones", zp[1][2][3], 16'hFFFF);
    end
    // start asserted mid-load must be ignored
    load(3, 0, N, -1);
    finish_load("spurious");
    // asynchronous reset mid-load
    load(0, 0, 5, -1);
    chk("mid_busy", {31'b0, busy}, 1);
    rst_n = 0;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_ready", {31'b0, in_ready}, 0);
    chk("arst_bufv", {31'b0, buf_valid}, 0);
    clear_model();
    cmp_buf("arst_buffer");
    step();
    rst_n = 1;
    step();
    load(1, 0, N, -1);
    finish_load("after_rst");
`ifdef ZP_LOADER_ABORT_EN
    load(2, 0, N, 4);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_bufv", {31'b0, buf_valid}, 0);
    drain();
    cmp_buf("abort_partial");
    step();
    chk("abort_no_done", {31'b0, done}, 0);
    load(3, 0, N, -1);
    finish_load("after_abort");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifmap_zeropad_loader.md
Name: ifmap_zeropad_loader

Overview:
- Upstream neighbour of the im2col rearrange stage.
- Accepts one ifmap (C channels × iH × iH, BF16) as a serial valid/ready element stream.
- Writes each element into a register buffer of size C × (iH+2P) × (iH+2P) at its padded position. Border cells are held at zero.
- Presents the buffer as a full unpacked array `ifmap_zeropad`, qualified by `buf_valid`, for the rearrange stage to consume combinationally.

Parameters:
- C, 3, number of ifmap channels
- iH, 4, ifmap height/width (square)
- P, 1, zero-padding size per side
- BW, 16, element width (BF16)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin loading a new ifmap
- in_valid  in  1  input element valid
- in_ready  out  1  loader can accept an element
- in_data  in  BW  input element
- done  out  1  one-cycle pulse on the cycle after the last element is accepted
- buf_valid  out  1  buffer holds a complete ifmap
- busy  out  1  high while in LOAD
- ifmap_zeropad  out  BW × [0:C-1][0:iH+2P-1][0:iH+2P-1]  padded buffer

Behaviour:
- Reset (async assert, sync release): state=IDLE; all buffer cells=0; in_ready=0, done=0, buf_valid=0, busy=0; counters ch/row/col=0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start=1 -> LOAD, counters cleared, buf_valid cleared.
  - LOAD:
    - in_ready=1 and busy=1 combinationally from state.
    - A beat is accepted when in_valid && in_ready.
    - Each beat writes ifmap_zeropad[ch][row+P][col+P] <= in_data.
    - Order: col fastest, then row, then ch. col wraps at iH-1 and increments row; row wraps at iH-1 and increments ch.
    - The beat at ch=C-1, row=iH-1, col=iH-1 -> DONE.
  - DONE: done=1 for exactly this one cycle; buf_valid=1 from this cycle onward; then -> IDLE.
- buf_valid stays high in IDLE until the next start is accepted.
- Border cells (row or col < P, or >= iH+P) are never written: held 0 from reset, always read 0. The implementation makes them constant 0, not flops.
- Interior cells are not cleared on start. All C·iH·iH cells are overwritten before buf_valid rises again.
- Latency:
  - start to first in_ready: 1 cycle.
  - last accepted beat to done: 1 cycle.
  - With in_valid held high, a full load takes C·iH·iH + 2 cycles from start.
- start while in LOAD or DONE: ignored; no counter reset.
- in_valid gaps: counters hold; no write.
- in_valid while not LOAD: ignored, no write; in_ready=0.
- Reset mid-LOAD: immediate return to reset values. Partial data is discarded (cells zeroed).
- Counter widths: $clog2 of each bound, minimum 1 bit.
- P=0 is legal: the buffer equals the ifmap and there is no border.

Optional Feature:
- Macro ZP_LOADER_ABORT_EN.
- Defined:
  - Extra input port abort (1 bit).
  - abort=1 in LOAD -> IDLE next cycle. Counters cleared, buf_valid stays 0, no done pulse.
  - A beat presented in the same cycle as abort is not written.
  - abort is ignored in IDLE and DONE.
- Undefined: the port does not exist and the behaviour is exactly as above.

Decomposition:
- Package zp_loader_pkg:
  - typedef bf16_t (logic [15:0]).
  - enum zp_state_t {IDLE, LOAD, DONE}.
  - function padded_dim(iH, P) = iH + 2P.
- One natural sub-module, zp_coord_counter:
  - Nested ch/row/col counter.
  - Inputs: clear, advance.
  - Outputs: ch, row, col, last. last is high at the final coordinate.

Test Plan:
- Basic load, C=2, iH=2, P=1: start, then 8 back-to-back beats 0x0001..0x0008 -> done pulses exactly 1 cycle after beat 8, buf_valid=1. ifmap_zeropad[0][1][1]=0x0001, [0][2][2]=0x0004, [1][1][1]=0x0005, [1][2][2]=0x0008. All 24 border cells = 0.
- Backpressure/gaps: same load with in_valid toggling 1,0,0,1,… -> identical final buffer; done arrives 1 cycle after the 8th accepted beat.
- Border integrity: default params, all in_data=0xFFFF -> all 48 interior cells = 0xFFFF. Rows 0 and 5 and columns 0 and 5 of every channel = 0.
- Spurious start: start asserted at beat 3 of LOAD -> no restart; load completes after the remaining beats; final contents correct.
- Reset mid-load: rst_n low after 5 beats -> all outputs and cells 0 immediately. A new start and a full load then complete correctly.
- Abort (ZP_LOADER_ABORT_EN defined): abort at beat 4 with in_valid=1 -> that beat is not written; state returns to IDLE; no done; buf_valid=0. Next start and full load succeed.
